dtt_crossbar_resp_router: RTL and testbench
===========================================

# dtt_crossbar_resp_router

Return-path router for the `dtt` crossbar fabric. It takes responses from the N_RSP crossbar output-side agents, each tagged with the index of the requester it belongs to, and steers them back to the N_REQ requester ports. Unlike the forward crossbar, it never drops a colliding transfer:
- per-requester round-robin arbitration resolves contention;
- valid/ready backpressure holds losing responders until they are served.

## Interface
Parameters:
- `N_RSP`, 4, number of responder (source) ports
- `N_REQ`, 4, number of requester (destination) ports
- `DATA_WIDTH`, 32, payload width
- `SRC_WIDTH`, `$clog2(N_REQ)`, requester-index tag width

Ports:
- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `rsp_data[N_RSP]`  in  DATA_WIDTH  response payload
- `rsp_src[N_RSP]`  in  SRC_WIDTH  destination requester index
- `rsp_valid[N_RSP]`  in  1  response present
- `rsp_ready[N_RSP]`  out  1  response accepted this cycle (combinational)
- `req_data[N_REQ]`  out  DATA_WIDTH  registered payload to requester
- `req_valid[N_REQ]`  out  1  registered valid to requester
- `req_ready[N_REQ]`  in  1  requester accepts `req_data`

## Operation
- **Per requester port j**
  - Holding register: `req_data[j]`, `req_valid[j]`.
  - Round-robin pointer `rr[j]`, range 0..N_RSP-1.
  - Port j can load when `!req_valid[j] || req_ready[j]`.
  - Candidate set: every i with `rsp_valid[i] && rsp_src[i]==j`.
  - Grant rule: first candidate scanning upward from `rr[j]` and wrapping modulo N_RSP.
- **On grant of i to j**
  - `rsp_ready[i]=1` in the same cycle.
  - Next edge: `req_data[j]<=rsp_data[i]`, `req_valid[j]<=1`, `rr[j]<=(i+1)%N_RSP`.
- **No grant**
  - If `req_ready[j]`: `req_valid[j]<=0`.
  - Otherwise: register holds. `req_data[j]` stays stable while `req_valid[j]` is high and `req_ready[j]` is low.
  - `rr[j]` changes only on a grant.
- **Handshake rules**
  - A responder is granted to at most one port, because `rsp_src` selects exactly one.
  - Non-granted responders see `rsp_ready=0` and must hold data and tag.
  - `rsp_ready` may depend on `rsp_valid`; `req_valid` never depends on `req_ready` combinationally.
- **Out-of-range tag** (`rsp_src>=N_REQ`, only possible for non-power-of-2 N_REQ): the response is consumed (`rsp_ready=1`) and discarded, with no effect on any requester port.

## Timing
- Reset values: `req_valid`=0, `req_data`=0, all `rr`=0, error outputs 0. While `rst` is high, `rsp_ready`=0.
- Latency: accept edge to `req_valid` high is 1 cycle.
- Throughput: 1 response/cycle per requester port while `req_ready` is held high, including back-to-back from different responders.
- Fairness: with K responders continuously contending for port j, each is served once every K grants.
- Full: with `req_valid[j]=1` and `req_ready[j]=0`, no grant is made to j; all candidates see `rsp_ready`=0.
- Drain-and-refill: with `req_valid[j]=1` and `req_ready[j]=1`, a new grant reloads j in the same cycle without a bubble.
- Reset mid-operation: pending register contents are discarded, pointers return to 0, and no `rsp_ready` is asserted during reset.

## Configuration
- Macro: `DTT_RSP_ROUTER_ERR_EN`.
- **Defined:** adds two outputs.
  - `err_pulse` (1 bit): high for one cycle after any out-of-range response is consumed.
  - `err_count` (16 bits): adds the number of out-of-range responses consumed that cycle and saturates at 16'hFFFF. Reset value 0.
- **Undefined:** ports and logic are absent; out-of-range responses are silently consumed and dropped.

## Test plan
- Single transfer:
  - Stimulus: rsp 2 sends data 32'hA5A5_0001 with src=1, with `req_ready[1]=1`.
  - Required: `rsp_ready[2]=1` that cycle; next cycle `req_valid[1]=1`, `req_data[1]`=32'hA5A5_0001.
- Contention:
  - Stimulus: rsp 0,1,3 all valid with src=2, held for 3 grants, `req_ready[2]=1`.
  - Required: deliveries in order 0,1,3; `rr[2]` ends at 0; no data lost.
- Backpressure:
  - Stimulus: `req_ready[0]=0` for 4 cycles with rsp 1 valid, src=0.
  - Required: `req_data[0]` stable; `rsp_ready[1]=0` until `req_ready[0]` rises, then accepted with no bubble.
- Parallel:
  - Stimulus: rsp i targets src=(3-i) for all 4 responders simultaneously.
  - Required: all four `rsp_ready` high the same cycle; all `req_valid` high next cycle with the matching data.
- Reset mid-operation:
  - Stimulus: assert `rst` while `req_valid[3]=1` and `req_ready[3]=0`.
  - Required: next cycle `req_valid[3]=0`, `req_data[3]`=0, all `rsp_ready`=0 during reset.
- Out-of-range tag (N_REQ=3, macro defined):
  - Stimulus: src=3 on rsp 0.
  - Required: `rsp_ready[0]=1`, no `req_valid` asserted, `err_pulse` for 1 cycle, `err_count`=1.

Source files
------------

// File: rtl/dtt_crossbar_resp_router.sv
// dtt crossbar return path: round-robin routing of tagged responses to requesters.
// Optional error reporting enabled by defining DTT_RSP_ROUTER_ERR_EN.
module dtt_crossbar_resp_router #(
   parameter int N_RSP      = 4,
   parameter int N_REQ      = 4,
   parameter int DATA_WIDTH = 32,
   parameter int SRC_WIDTH  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] rsp_data  [N_RSP],
   input  logic [SRC_WIDTH-1:0]  rsp_src   [N_RSP],
   input  logic                  rsp_valid [N_RSP],
   output logic                  rsp_ready [N_RSP],
   output logic [DATA_WIDTH-1:0] req_data  [N_REQ],
   output logic                  req_valid [N_REQ],
   input  logic                  req_ready [N_REQ]
`ifdef DTT_RSP_ROUTER_ERR_EN
   ,
   output logic                  err_pulse,
   output logic [15:0]           err_count
`endif
);

   localparam int IDX_W = (N_RSP > 1) ? $clog2(N_RSP) : 1;

   logic [IDX_W-1:0] rr      [N_REQ];
   logic             gnt_vld [N_REQ];
   logic [IDX_W-1:0] gnt_idx [N_REQ];

   // per-port round-robin pick, plus ready for winners and stray tags
   always_comb begin
      int idx;
      idx = 0;
      for (int j = 0; j < N_REQ; j++) begin
         gnt_vld[j] = 1'b0;
         gnt_idx[j] = '0;
      end
      for (int i = 0; i < N_RSP; i++) begin
         rsp_ready[i] = 1'b0;
      end
      if (!rst) begin
         for (int j = 0; j < N_REQ; j++) begin
            if (!req_valid[j] || req_ready[j]) begin
               for (int k = 0; k < N_RSP; k++) begin
                  idx = int'(rr[j]) + k;
                  if (idx >= N_RSP) idx = idx - N_RSP;
                  if (!gnt_vld[j] && rsp_valid[idx] &&
                      rsp_src[idx] == SRC_WIDTH'(j)) begin
                     gnt_vld[j] = 1'b1;
                     gnt_idx[j] = IDX_W'(idx);
                  end
               end
            end
         end
         for (int i = 0; i < N_RSP; i++) begin
            if (rsp_valid[i] && int'(rsp_src[i]) >= N_REQ)
               rsp_ready[i] = 1'b1;
         end
         for (int j = 0; j < N_REQ; j++) begin
            if (gnt_vld[j]) rsp_ready[gnt_idx[j]] = 1'b1;
         end
      end
   end

   // holding registers and pointers; pointer moves past the winner
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int j = 0; j < N_REQ; j++) begin
            req_valid[j] <= 1'b0;
            req_data[j]  <= '0;
            rr[j]        <= '0;
         end
      end else begin
         for (int j = 0; j < N_REQ; j++) begin
            if (gnt_vld[j]) begin
               req_data[j]  <= rsp_data[gnt_idx[j]];
               req_valid[j] <= 1'b1;
               rr[j]        <= (int'(gnt_idx[j]) == N_RSP-1) ?
                               '0 : gnt_idx[j] + 1'b1;
            end else if (req_ready[j]) begin
               req_valid[j] <= 1'b0;
            end
         end
      end
   end

`ifdef DTT_RSP_ROUTER_ERR_EN
   logic [15:0] n_oor;
   logic [16:0] err_sum;

   // number of stray-tag responses consumed this cycle
   always_comb begin
      n_oor = '0;
      if (!rst) begin
         for (int i = 0; i < N_RSP; i++) begin
            if (rsp_valid[i] && int'(rsp_src[i]) >= N_REQ)
               n_oor = n_oor + 16'd1;
         end
      end
   end

   assign err_sum = {1'b0, err_count} + {1'b0, n_oor};

   // one-cycle pulse and saturating tally of dropped responses
   always_ff @(posedge clk) begin
      if (rst) begin
         err_pulse <= 1'b0;
         err_count <= '0;
      end else begin
         err_pulse <= |n_oor;
         err_count <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
      end
   end
`endif

endmodule

// File: tb/tb_dtt_crossbar_resp_router.sv
// Bench for dtt_crossbar_resp_router: directed scenarios plus randomized
// traffic checked against a behavioural routing model.
module tb_dtt_crossbar_resp_router;

   localparam int N  = 4;
   localparam int DW = 32;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [DW-1:0] rsp_data  [N];
   logic [1:0]    rsp_src   [N];
   logic          rsp_valid [N];
   logic          rsp_ready [N];
   logic [DW-1:0] req_data  [N];
   logic          req_valid [N];
   logic          req_ready [N];

   logic [1:0]    rsp3_src   [N];
   logic          rsp3_valid [N];
   logic          rsp3_ready [N];
   logic [DW-1:0] req3_data  [3];
   logic          req3_valid [3];
   logic          req3_ready [3];

`ifdef DTT_RSP_ROUTER_ERR_EN
   logic        err_pulse, err_pulse3;
   logic [15:0] err_count, err_count3;
`endif

   int checks = 0;
   int errors = 0;

   dtt_crossbar_resp_router #(.N_RSP(N), .N_REQ(N), .DATA_WIDTH(DW)) u_dut (
      .clk(clk), .rst(rst),
      .rsp_data(rsp_data), .rsp_src(rsp_src),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .req_data(req_data), .req_valid(req_valid), .req_ready(req_ready)
`ifdef DTT_RSP_ROUTER_ERR_EN
      , .err_pulse(err_pulse), .err_count(err_count)
`endif
   );

   dtt_crossbar_resp_router #(.N_RSP(N), .N_REQ(3), .DATA_WIDTH(DW)) u_dut3 (
      .clk(clk), .rst(rst),
      .rsp_data(rsp_data), .rsp_src(rsp3_src),
      .rsp_valid(rsp3_valid), .rsp_ready(rsp3_ready),
      .req_data(req3_data), .req_valid(req3_valid), .req_ready(req3_ready)
`ifdef DTT_RSP_ROUTER_ERR_EN
      , .err_pulse(err_pulse3), .err_count(err_count3)
`endif
   );

   task automatic idle();
      for (int i = 0; i < N; i++) begin
         rsp_valid[i]  = 1'b0;
         rsp_data[i]   = '0;
         rsp_src[i]    = '0;
         rsp3_valid[i] = 1'b0;
         rsp3_src[i]   = '0;
         req_ready[i]  = 1'b1;
      end
      for (int j = 0; j < 3; j++) req3_ready[j] = 1'b1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle();
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic edge_();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle();
      for (int i = 0; i < N; i++) begin
         rsp_valid[i] = 1'b1;
         rsp_src[i]   = 2'(i);
         rsp_data[i]  = 32'hDEAD_0000 + i;
      end
      #1;
      for (int i = 0; i < N; i++) begin
         checks++;
         if (rsp_ready[i] !== 1'b0) begin
            errors++;
            $display("FAIL reset_rsp_ready[%0d] got %b want 0", i, rsp_ready[i]);
         end
      end
      edge_();
      for (int j = 0; j < N; j++) begin
         checks++;
         if (req_valid[j] !== 1'b0 || req_data[j] !== '0) begin
            errors++;
            $display("FAIL reset_req[%0d] got v=%b d=%h want v=0 d=0",
                     j, req_valid[j], req_data[j]);
         end
      end
`ifdef DTT_RSP_ROUTER_ERR_EN
      checks++;
      if (err_pulse !== 1'b0 || err_count !== 16'd0) begin
         errors++;
         $display("FAIL reset_err got p=%b c=%0d want 0 0", err_pulse, err_count);
      end
`endif
      @(negedge clk);
      do_reset();
   endtask

   task automatic test_single();
      do_reset();
      rsp_valid[2] = 1'b1;
      rsp_src[2]   = 2'd1;
      rsp_data[2]  = 32'hA5A5_0001;
      req_ready[1] = 1'b1;
      #1;
      checks++;
      if (rsp_ready[2] !== 1'b1) begin
         errors++;
         $display("FAIL single_rsp_ready got %b want 1", rsp_ready[2]);
      end
      edge_();
      rsp_valid[2] = 1'b0;
      checks++;
      if (req_valid[1] !== 1'b1 || req_data[1] !== 32'hA5A5_0001) begin
         errors++;
         $display("FAIL single_req got v=%b d=%h want v=1 d=a5a50001",
                  req_valid[1], req_data[1]);
      end
      @(negedge clk);
   endtask

   task automatic test_contention();
      int order [3];
      order = '{0, 1, 3};
      do_reset();
      foreach (order[g]) begin
         rsp_valid[order[g]] = 1'b1;
         rsp_src[order[g]]   = 2'd2;
         rsp_data[order[g]]  = 32'hC0DE_0000 + order[g];
      end
      for (int g = 0; g < 3; g++) begin
         #1;
         for (int i = 0; i < N; i++) begin
            checks++;
            if (rsp_ready[i] !== (i == order[g])) begin
               errors++;
               $display("FAIL contention_rdy g%0d rsp%0d got %b want %b",
                        g, i, rsp_ready[i], (i == order[g]));
            end
         end
         edge_();
         rsp_valid[order[g]] = 1'b0;
         checks++;
         if (req_valid[2] !== 1'b1 || req_data[2] !== 32'hC0DE_0000 + order[g]) begin
            errors++;
            $display("FAIL contention_data g%0d got %h want %h",
                     g, req_data[2], 32'hC0DE_0000 + order[g]);
         end
         @(negedge clk);
      end
      // pointer should be back at 0: rsp 0 beats rsp 3
      rsp_valid[0] = 1'b1;
      rsp_valid[3] = 1'b1;
      #1;
      checks++;
      if (rsp_ready[0] !== 1'b1 || rsp_ready[3] !== 1'b0) begin
         errors++;
         $display("FAIL contention_rr got r0=%b r3=%b want 1 0",
                  rsp_ready[0], rsp_ready[3]);
      end
      @(negedge clk);
      idle();
   endtask

   task automatic test_backpressure();
      do_reset();
      req_ready[0] = 1'b0;
      rsp_valid[2] = 1'b1;
      rsp_src[2]   = 2'd0;
      rsp_data[2]  = 32'h1111_2222;
      edge_();
      rsp_valid[2] = 1'b0;
      rsp_valid[1] = 1'b1;
      rsp_src[1]   = 2'd0;
      rsp_data[1]  = 32'h3333_4444;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         #1;
         checks++;
         if (rsp_ready[1] !== 1'b0) begin
            errors++;
            $display("FAIL bp_rdy c%0d got %b want 0", c, rsp_ready[1]);
         end
         edge_();
         checks++;
         if (req_valid[0] !== 1'b1 || req_data[0] !== 32'h1111_2222) begin
            errors++;
            $display("FAIL bp_hold c%0d got v=%b d=%h want v=1 d=11112222",
                     c, req_valid[0], req_data[0]);
         end
      end
      @(negedge clk);
      req_ready[0] = 1'b1;
      #1;
      checks++;
      if (rsp_ready[1] !== 1'b1) begin
         errors++;
         $display("FAIL bp_release got %b want 1", rsp_ready[1]);
      end
      edge_();
      rsp_valid[1] = 1'b0;
      checks++;
      if (req_valid[0] !== 1'b1 || req_data[0] !== 32'h3333_4444) begin
         errors++;
         $display("FAIL bp_refill got v=%b d=%h want v=1 d=33334444",
                  req_valid[0], req_data[0]);
      end
      edge_();
      checks++;
      if (req_valid[0] !== 1'b0) begin
         errors++;
         $display("FAIL bp_drain got %b want 0", req_valid[0]);
      end
      @(negedge clk);
   endtask

   task automatic test_parallel();
      do_reset();
      for (int i = 0; i < N; i++) begin
         rsp_valid[i] = 1'b1;
         rsp_src[i]   = 2'(3 - i);
         rsp_data[i]  = 32'h0000_1000 + i;
      end
      #1;
      for (int i = 0; i < N; i++) begin
         checks++;
         if (rsp_ready[i] !== 1'b1) begin
            errors++;
            $display("FAIL parallel_rdy[%0d] got %b want 1", i, rsp_ready[i]);
         end
      end
      edge_();
      idle();
      for (int i = 0; i < N; i++) begin
         checks++;
         if (req_valid[3-i] !== 1'b1 || req_data[3-i] !== 32'h0000_1000 + i) begin
            errors++;
            $display("FAIL parallel_req[%0d] got v=%b d=%h want v=1 d=%h",
                     3 - i, req_valid[3-i], req_data[3-i], 32'h0000_1000 + i);
         end
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      do_reset();
      req_ready[3] = 1'b0;
      rsp_valid[1] = 1'b1;
      rsp_src[1]   = 2'd3;
      rsp_data[1]  = 32'h7777_0003;
      edge_();
      rsp_data[1]  = 32'h7777_0004;
      checks++;
      if (req_valid[3] !== 1'b1) begin
         errors++;
         $display("FAIL midrst_load got %b want 1", req_valid[3]);
      end
      @(negedge clk);
      rst = 1'b1;
      rsp_valid[0] = 1'b1;
      rsp_src[0]   = 2'd0;
      #1;
      for (int i = 0; i < N; i++) begin
         checks++;
         if (rsp_ready[i] !== 1'b0) begin
            errors++;
            $display("FAIL midrst_rdy[%0d] got %b want 0", i, rsp_ready[i]);
         end
      end
      edge_();
      checks++;
      if (req_valid[3] !== 1'b0 || req_data[3] !== '0 || req_valid[0] !== 1'b0) begin
         errors++;
         $display("FAIL midrst_req got v3=%b d3=%h v0=%b want 0 0 0",
                  req_valid[3], req_data[3], req_valid[0]);
      end
      @(negedge clk);
      do_reset();
   endtask

   task automatic test_oor();
      do_reset();
      rsp3_valid[0] = 1'b1;
      rsp3_src[0]   = 2'd3;
      rsp_data[0]   = 32'hBAD0_0003;
      #1;
      checks++;
      if (rsp3_ready[0] !== 1'b1) begin
         errors++;
         $display("FAIL oor_rdy got %b want 1", rsp3_ready[0]);
      end
      edge_();
      rsp3_valid[0] = 1'b0;
      for (int j = 0; j < 3; j++) begin
         checks++;
         if (req3_valid[j] !== 1'b0) begin
            errors++;
            $display("FAIL oor_req[%0d] got %b want 0", j, req3_valid[j]);
         end
      end
`ifdef DTT_RSP_ROUTER_ERR_EN
      checks++;
      if (err_pulse3 !== 1'b1 || err_count3 !== 16'd1) begin
         errors++;
         $display("FAIL oor_err got p=%b c=%0d want 1 1", err_pulse3, err_count3);
      end
      edge_();
      checks++;
      if (err_pulse3 !== 1'b0 || err_count3 !== 16'd1) begin
         errors++;
         $display("FAIL oor_err2 got p=%b c=%0d want 0 1", err_pulse3, err_count3);
      end
`endif
      @(negedge clk);
   endtask

   task automatic test_random();
      logic          p_valid [N];
      logic [1:0]    p_src   [N];
      logic [DW-1:0] p_data  [N];
      logic          e_valid [N];
      logic [DW-1:0] e_data  [N];
      int            ptr     [N];
      int            win     [N];
      logic          e_rdy   [N];
      int            best;
      do_reset();
      for (int i = 0; i < N; i++) begin
         p_valid[i] = 1'b0;
         p_src[i]   = '0;
         p_data[i]  = '0;
         e_valid[i] = 1'b0;
         e_data[i]  = '0;
         ptr[i]     = 0;
      end
      for (int c = 0; c < 300; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!p_valid[i] && $urandom_range(9) < 6) begin
               p_valid[i] = 1'b1;
               p_src[i]   = 2'($urandom_range(3));
               p_data[i]  = $urandom;
            end
            rsp_valid[i] = p_valid[i];
            rsp_src[i]   = p_src[i];
            rsp_data[i]  = p_data[i];
            req_ready[i] = ($urandom_range(3) != 0);
         end
         // model: winner is the candidate at least distance from the pointer
         for (int i = 0; i < N; i++) e_rdy[i] = 1'b0;
         for (int j = 0; j < N; j++) begin
            win[j] = -1;
            best = N;
            if (!e_valid[j] || req_ready[j]) begin
               for (int i = 0; i < N; i++) begin
                  if (p_valid[i] && int'(p_src[i]) == j &&
                      ((i - ptr[j] + N) % N) < best) begin
                     best   = (i - ptr[j] + N) % N;
                     win[j] = i;
                  end
               end
            end
            if (win[j] >= 0) e_rdy[win[j]] = 1'b1;
         end
         #1;
         for (int i = 0; i < N; i++) begin
            checks++;
            if (rsp_ready[i] !== e_rdy[i]) begin
               errors++;
               $display("FAIL rand_rdy c%0d rsp%0d got %b want %b",
                        c, i, rsp_ready[i], e_rdy[i]);
            end
         end
         edge_();
         for (int j = 0; j < N; j++) begin
            if (win[j] >= 0) begin
               e_valid[j]      = 1'b1;
               e_data[j]       = p_data[win[j]];
               ptr[j]          = (win[j] + 1) % N;
               p_valid[win[j]] = 1'b0;
            end else if (req_ready[j]) begin
               e_valid[j] = 1'b0;
            end
            checks++;
            if (req_valid[j] !== e_valid[j] || req_data[j] !== e_data[j]) begin
               errors++;
               $display("FAIL rand_req c%0d port%0d got v=%b d=%h want v=%b d=%h",
                        c, j, req_valid[j], req_data[j], e_valid[j], e_data[j]);
            end
         end
         @(negedge clk);
      end
      idle();
   endtask

   initial begin
      rst = 1'b1;
      idle();
      @(negedge clk);
      test_reset();
      test_single();
      test_contention();
      test_backpressure();
      test_parallel();
      test_reset_mid();
      test_oor();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
